// File: rtl/menu_controller_if.sv
// Button/game inputs and menu datapath controls for menu_controller.
// master = controller side, slave = buttons, game FSM and menu datapath side.
interface menu_controller_if #(
  parameter int N_SR = 5
);
  logic            iniciar;
  logic            confirma;
  logic            volta;
  logic            seta;
  logic            jogo_fim;
  logic            jogo_erro;
  logic [1:0]      menu_sel;
  logic            load_initial;
  logic [N_SR-1:0] shift_en;
  logic            menu_ativo;
  logic            inicia_jogo;
  logic [3:0]      estado;

  modport master (
    input  iniciar, confirma, volta, seta, jogo_fim, jogo_erro,
    output menu_sel, load_initial, shift_en, menu_ativo, inicia_jogo, estado
  );

  modport slave (
    output iniciar, confirma, volta, seta, jogo_fim, jogo_erro,
    input  menu_sel, load_initial, shift_en, menu_ativo, inicia_jogo, estado
  );
endinterface

// File: rtl/menu_controller.sv
// Menu sequencer: synchronised button edges drive a Moore FSM; a button rise changes state 2 edges later.
// No backpressure; outputs decode only from state. MENU_TIMEOUT_EN adds an inactivity return to IDLE.
module menu_controller #(
  parameter int N_SR           = 5,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  menu_controller_if.master mif
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    INIT       = 4'd1,
    SEL_MODO   = 4'd2,
    SEL_BPM    = 4'd3,
    SEL_TOM    = 4'd4,
    SEL_MUSICA = 4'd5,
    START      = 4'd6,
    PLAYING    = 4'd7,
    SEL_ERRO   = 4'd8
  } state_t;

  state_t state;
  state_t state_next;

  // Bit order {volta, confirma, iniciar}
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] prev;
  logic [2:0] pulse;
  logic       ini_p;
  logic       conf_p;
  logic       vol_p;
  logic       timeout_hit;

  assign btn_raw = {mif.volta, mif.confirma, mif.iniciar};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse  = sync2 & ~prev;
  assign ini_p  = pulse[0];
  assign conf_p = pulse[1];
  assign vol_p  = pulse[2];

`ifdef MENU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] idle_cnt;
  logic          in_sel;
  logic          activity;

  assign in_sel      = (state inside {SEL_MODO, SEL_BPM, SEL_TOM, SEL_MUSICA, SEL_ERRO});
  assign activity    = (|pulse) | mif.seta;
  // Activity in the terminal-count cycle cancels the timeout
  assign timeout_hit = in_sel && !activity && (idle_cnt == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if ((state_next != state) || activity || !in_sel) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // volta beats confirma, jogo_erro beats jogo_fim
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (ini_p) state_next = INIT;
      INIT:       state_next = SEL_MODO;
      SEL_MODO:   if (vol_p) state_next = IDLE;       else if (conf_p) state_next = SEL_BPM;
      SEL_BPM:    if (vol_p) state_next = SEL_MODO;   else if (conf_p) state_next = SEL_TOM;
      SEL_TOM:    if (vol_p) state_next = SEL_BPM;    else if (conf_p) state_next = SEL_MUSICA;
      SEL_MUSICA: if (vol_p) state_next = SEL_TOM;    else if (conf_p) state_next = START;
      START:      state_next = PLAYING;
      PLAYING:    if (mif.jogo_erro) state_next = SEL_ERRO; else if (mif.jogo_fim) state_next = IDLE;
      SEL_ERRO:   if (vol_p) state_next = IDLE;       else if (conf_p) state_next = START;
      default:    state_next = IDLE;
    endcase
    if (timeout_hit) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    mif.menu_sel     = 2'd0;
    mif.load_initial = 1'b0;
    mif.shift_en     = '0;
    mif.menu_ativo   = 1'b0;
    mif.inicia_jogo  = 1'b0;
    case (state)
      INIT: begin
        mif.load_initial = 1'b1;
        mif.menu_ativo   = 1'b1;
      end
      SEL_MODO: begin
        mif.shift_en[0] = 1'b1;
        mif.menu_ativo  = 1'b1;
      end
      SEL_BPM: begin
        mif.menu_sel    = 2'd1;
        mif.shift_en[1] = 1'b1;
        mif.menu_ativo  = 1'b1;
      end
      SEL_TOM: begin
        mif.menu_sel    = 2'd2;
        mif.shift_en[2] = 1'b1;
        mif.menu_ativo  = 1'b1;
      end
      SEL_MUSICA: begin
        mif.menu_sel    = 2'd3;
        mif.shift_en[3] = 1'b1;
        mif.menu_ativo  = 1'b1;
      end
      START: begin
        mif.menu_sel    = 2'd3;
        mif.menu_ativo  = 1'b1;
        mif.inicia_jogo = 1'b1;
      end
      PLAYING: begin
        mif.menu_sel = 2'd3;
      end
      SEL_ERRO: begin
        mif.menu_sel    = 2'd3;
        mif.shift_en[4] = 1'b1;
        mif.menu_ativo  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mif.estado = state;

endmodule

// File: tb/tb_menu_controller.sv
// Directed and random stimulus against a per-edge behavioural model of the menu sequence.
module tb_menu_controller;
  localparam int TO = 8;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  int   ms;
  int   mcnt;
  logic [2:0] btn;
  logic [2:0] pend [8];

  menu_controller_if #(.N_SR(5)) bus ();

  menu_controller #(.N_SR(5), .TIMEOUT_CYCLES(TO)) dut (
    .clock (clock),
    .reset (reset),
    .mif   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Button pulse seen by the FSM two edges after the edge that first samples the rise
  task automatic set_buttons(input logic [2:0] v);
    logic [2:0] rise;
    rise = v & ~btn;
    pend[(cyc + 3) % 8] = pend[(cyc + 3) % 8] | rise;
    btn          = v;
    bus.iniciar  = v[0];
    bus.confirma = v[1];
    bus.volta    = v[2];
  endtask

  task automatic model_step(input logic [2:0] p);
    int  nxt;
    bit  in_sel;
    bit  act;
    nxt = ms;
    case (ms)
      0: if (p[0]) nxt = 1;
      1: nxt = 2;
      6: nxt = 7;
      7: if (bus.jogo_erro) nxt = 8; else if (bus.jogo_fim) nxt = 0;
      default: begin
        if (p[2])      nxt = (ms == 2 || ms == 8) ? 0 : ms - 1;
        else if (p[1]) nxt = (ms == 8) ? 6 : ms + 1;
      end
    endcase
    in_sel = (ms >= 2 && ms <= 5) || ms == 8;
    act    = (p != 3'b000) || bus.seta;
`ifdef MENU_TIMEOUT_EN
    if (in_sel && !act && mcnt == TO - 1) nxt = 0;
    mcnt = (nxt != ms || act || !in_sel) ? 0 : mcnt + 1;
`endif
    ms = nxt;
  endtask

  task automatic check_outputs();
    logic [31:0] e_sel;
    logic [31:0] e_sh;
    e_sel = (ms >= 2 && ms <= 5) ? 32'(ms - 2) : ((ms >= 6 && ms <= 8) ? 32'd3 : 32'd0);
    e_sh  = (ms >= 2 && ms <= 5) ? (32'd1 << (ms - 2)) : ((ms == 8) ? 32'd16 : 32'd0);
    chk("estado", bus.estado, 32'(ms));
    chk("menu_sel", bus.menu_sel, e_sel);
    chk("shift_en", bus.shift_en, e_sh);
    chk("load_initial", bus.load_initial, 32'(ms == 1));
    chk("menu_ativo", bus.menu_ativo, 32'((ms >= 1 && ms <= 6) || ms == 8));
    chk("inicia_jogo", bus.inicia_jogo, 32'(ms == 6));
  endtask

  task automatic tick();
    logic [2:0] p;
    @(posedge clock);
    cyc++;
    p = pend[cyc % 8];
    pend[cyc % 8] = 3'b000;
    if (!reset) begin
      ms   = 0;
      mcnt = 0;
    end else begin
      model_step(p);
    end
    #1;
    check_outputs();
  endtask

  task automatic press(input logic [2:0] mask);
    set_buttons(mask);
    tick();
    set_buttons(3'b000);
    tick();
    tick();
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; ms = 0; mcnt = 0; btn = 3'b000;
    for (int i = 0; i < 8; i++) pend[i] = 3'b000;
    reset = 1'b0;
    bus.iniciar = 1'b0; bus.confirma = 1'b0; bus.volta = 1'b0;
    bus.seta = 1'b0; bus.jogo_fim = 1'b0; bus.jogo_erro = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_estado", bus.estado, 32'd0);
    chk("rst_shift", bus.shift_en, 32'd0);
    chk("rst_ativo", bus.menu_ativo, 32'd0);
    #2 reset = 1'b1;
    tick();

    // 1: start sequence, one-cycle initial load
    press(3'b001);
    chk("t1_init", bus.estado, 32'd1);
    chk("t1_load", bus.load_initial, 32'd1);
    tick();
    chk("t1_modo", bus.estado, 32'd2);
    chk("t1_load_off", bus.load_initial, 32'd0);
    chk("t1_shift", bus.shift_en, 32'd1);
    chk("t1_sel", bus.menu_sel, 32'd0);

    // 2: walk through the menu into PLAYING
    press(3'b010); chk("t2_sel_bpm", bus.menu_sel, 32'd1);
    press(3'b010); chk("t2_sel_tom", bus.menu_sel, 32'd2);
    press(3'b010); chk("t2_sel_mus", bus.menu_sel, 32'd3);
    press(3'b010); chk("t2_start", bus.inicia_jogo, 32'd1);
    tick();
    chk("t2_playing", bus.estado, 32'd7);
    chk("t2_ativo", bus.menu_ativo, 32'd0);
    chk("t2_pulse_off", bus.inicia_jogo, 32'd0);

    // 4: simultaneous game pulses, error wins; retry
    bus.jogo_erro = 1'b1; bus.jogo_fim = 1'b1;
    tick();
    bus.jogo_erro = 1'b0; bus.jogo_fim = 1'b0;
    chk("t4_erro", bus.estado, 32'd8);
    chk("t4_shift", bus.shift_en, 32'd16);
    press(3'b010);
    chk("t4_retry", bus.estado, 32'd6);
    tick();
    chk("t4_play", bus.estado, 32'd7);
    bus.jogo_fim = 1'b1;
    tick();
    bus.jogo_fim = 1'b0;
    chk("t4_fim", bus.estado, 32'd0);

    // 3: volta beats confirma; volta from SEL_MODO goes IDLE
    press(3'b001); tick();
    press(3'b010); press(3'b010);
    chk("t3_tom", bus.estado, 32'd4);
    press(3'b110);
    chk("t3_back", bus.estado, 32'd3);
    chk("t3_sel", bus.menu_sel, 32'd1);
    press(3'b100);
    press(3'b100);
    chk("t3_idle", bus.estado, 32'd0);

    // 5: asynchronous reset from SEL_MUSICA
    press(3'b001); tick();
    press(3'b010); press(3'b010); press(3'b010);
    chk("t5_mus", bus.estado, 32'd5);
    @(negedge clock);
    reset = 1'b0;
    #1;
    ms = 0; mcnt = 0;
    chk("t5_estado", bus.estado, 32'd0);
    chk("t5_sel", bus.menu_sel, 32'd0);
    chk("t5_shift", bus.shift_en, 32'd0);
    chk("t5_ativo", bus.menu_ativo, 32'd0);
    tick();
    #2 reset = 1'b1;
    tick(); tick();

`ifdef MENU_TIMEOUT_EN
    // 6: inactivity timeout and seta keeping the menu alive
    press(3'b001); tick();
    press(3'b010);
    chk("t6_bpm", bus.estado, 32'd3);
    for (int i = 0; i < 7; i++) tick();
    chk("t6_wait", bus.estado, 32'd3);
    tick();
    chk("t6_timeout", bus.estado, 32'd0);
    press(3'b001); tick();
    press(3'b010);
    for (int i = 0; i < 7; i++) tick();
    bus.seta = 1'b1;
    tick();
    bus.seta = 1'b0;
    chk("t6_seta", bus.estado, 32'd3);
    press(3'b100); press(3'b100);
    chk("t6_idle", bus.estado, 32'd0);
`endif

    // random phase: every edge compared with the model
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] v;
      v = btn;
      if ($urandom_range(0, 5) == 0) v[0] = ~v[0];
      if ($urandom_range(0, 2) == 0) v[1] = ~v[1];
      if ($urandom_range(0, 7) == 0) v[2] = ~v[2];
      set_buttons(v);
      bus.jogo_erro = ($urandom_range(0, 11) == 0);
      bus.jogo_fim  = ($urandom_range(0, 7) == 0);
      bus.seta      = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
